// File: rtl/spi_display_fill.sv
// spi_display_fill: rectangle-fill command generator for SPI TFT panels.
// Emits CASET/RASET window setup, RAMWR, then one solid colour per pixel as
// a {dc, byte} word stream with a get/empty handshake.
// Optional feature macro: FILL_RGB666_EN (3 bytes per pixel, 18-bit format);
// when undefined, pixels are sent as 2 bytes of RGB565.
module spi_display_fill #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] y1,
  input  logic [15:0]  colour,
  output logic [8:0]   out,
  input  logic         get,
  output logic         empty,
  output logic         busy,
  output logic         done
);

`ifdef FILL_RGB666_EN
  localparam int B = 3;
`else
  localparam int B = 2;
`endif

  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, PIXEL} state_t;

  state_t         state;
  logic [2:0]     idx;
  logic [1:0]     bidx;
  logic [2*W:0]   count;
  logic [W-1:0]   lx0, lx1, ly0, ly1;
  logic [15:0]    lcol;

  logic           window_ok;
  logic           pop;
  logic [2*W:0]   n_pix;

  // Coordinates go out as the low byte of a 16-bit value, zero-extended.
  function automatic logic [7:0] coord_byte(input logic [W-1:0] c);
    logic [7:0] v;
    v = '0;
    v[W-1:0] = c;
    return v;
  endfunction

  // Word for position i (1..4) of a CASET/RASET parameter list: 00,a,00,b.
  function automatic logic [8:0] param_word(input logic [2:0] i, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    case (i)
      3'd2:    return {1'b1, coord_byte(a)};
      3'd4:    return {1'b1, coord_byte(b)};
      default: return 9'h100;
    endcase
  endfunction

  // Data word carrying byte i of one pixel in the selected panel format.
  function automatic logic [8:0] pixel_word(input logic [1:0] i, input logic [15:0] c);
`ifdef FILL_RGB666_EN
    case (i)
      2'd0:    return {1'b1, c[15:11], c[15], 2'b00};
      2'd1:    return {1'b1, c[10:5], 2'b00};
      default: return {1'b1, c[4:0], c[4], 2'b00};
    endcase
`else
    case (i)
      2'd0:    return {1'b1, c[15:8]};
      default: return {1'b1, c[7:0]};
    endcase
`endif
  endfunction

  // Window validity and pixel count are evaluated on the raw inputs so they
  // can be latched together with them when start is accepted.
  always_comb begin
    window_ok = (x0 <= x1) && (y0 <= y1);
    n_pix = (2*W+1)'({1'b0, x1} - {1'b0, x0} + (W+1)'(1))
          * (2*W+1)'({1'b0, y1} - {1'b0, y0} + (W+1)'(1));
    pop = get && !empty;
  end

  // Sequencer: every output is registered, each pop advances one word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      bidx  <= '0;
      count <= '0;
      lx0   <= '0;
      lx1   <= '0;
      ly0   <= '0;
      ly1   <= '0;
      lcol  <= '0;
      out   <= 9'h000;
      empty <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (window_ok) begin
              lx0   <= x0;
              lx1   <= x1;
              ly0   <= y0;
              ly1   <= y1;
              lcol  <= colour;
              count <= n_pix;
              idx   <= '0;
              bidx  <= '0;
              out   <= 9'h02A;
              empty <= 1'b0;
              busy  <= 1'b1;
              state <= CASET;
            end else begin
              done <= 1'b1;
            end
          end
        end
        CASET: begin
          if (pop) begin
            if (idx == 3'd4) begin
              idx   <= '0;
              out   <= 9'h02B;
              state <= RASET;
            end else begin
              idx <= idx + 3'd1;
              out <= param_word(idx + 3'd1, lx0, lx1);
            end
          end
        end
        RASET: begin
          if (pop) begin
            if (idx == 3'd4) begin
              idx   <= '0;
              out   <= 9'h02C;
              state <= RAMWR;
            end else begin
              idx <= idx + 3'd1;
              out <= param_word(idx + 3'd1, ly0, ly1);
            end
          end
        end
        RAMWR: begin
          if (pop) begin
            bidx  <= '0;
            out   <= pixel_word(2'd0, lcol);
            state <= PIXEL;
          end
        end
        PIXEL: begin
          if (pop) begin
            if (bidx == 2'(B - 1)) begin
              bidx <= '0;
              if (count == (2*W+1)'(1)) begin
                count <= '0;
                out   <= 9'h000;
                empty <= 1'b1;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= IDLE;
              end else begin
                count <= count - (2*W+1)'(1);
                out   <= pixel_word(2'd0, lcol);
              end
            end else begin
              bidx <= bidx + 2'd1;
              out  <= pixel_word(bidx + 2'd1, lcol);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_display_fill.sv
// tb_spi_display_fill: directed self-checking bench for spi_display_fill.
// Honours FILL_RGB666_EN to select the expected pixel byte tables.
module tb_spi_display_fill;

  localparam int W = 8;

`ifdef FILL_RGB666_EN
  localparam int NB = 3;
  localparam logic [8:0] F800_0 = 9'h1FC, F800_1 = 9'h100, F800_2 = 9'h100;
  localparam logic [8:0] C1234_0 = 9'h110, C1234_1 = 9'h144, C1234_2 = 9'h1A4;
  localparam logic [8:0] CABCD_0 = 9'h1AC, CABCD_1 = 9'h178, CABCD_2 = 9'h168;
`else
  localparam int NB = 2;
  localparam logic [8:0] F800_0 = 9'h1F8, F800_1 = 9'h100, F800_2 = 9'h000;
  localparam logic [8:0] C1234_0 = 9'h112, C1234_1 = 9'h134, C1234_2 = 9'h000;
  localparam logic [8:0] CABCD_0 = 9'h1AB, CABCD_1 = 9'h1CD, CABCD_2 = 9'h000;
`endif

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [W-1:0] x0, x1, y0, y1;
  logic [15:0]  colour;
  logic [8:0]   out;
  logic         get;
  logic         empty;
  logic         busy;
  logic         done;

  int checks;
  int errors;
  logic [8:0] exp_q[$];

  spi_display_fill #(.W(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .x0      (x0),
    .x1      (x1),
    .y0      (y0),
    .y1      (y1),
    .colour  (colour),
    .out     (out),
    .get     (get),
    .empty   (empty),
    .busy    (busy),
    .done    (done)
  );

  // 10 ns clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [W-1:0] ax0, input logic [W-1:0] ax1,
                               input logic [W-1:0] ay0, input logic [W-1:0] ay1,
                               input logic [15:0] acol);
    x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; colour = acol;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pushPixels(input int n, input logic [8:0] b0, input logic [8:0] b1,
                            input logic [8:0] b2);
    for (int p = 0; p < n; p++) begin
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      if (NB == 3) exp_q.push_back(b2);
    end
  endtask

  task automatic popWords(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      checkOutput($sformatf("word%0d", i), 32'(out), 32'(exp_q[i]));
      checkOutput($sformatf("empty%0d", i), 32'(empty), 32'd0);
      checkOutput($sformatf("busy%0d", i), 32'(busy), 32'd1);
      checkOutput($sformatf("done%0d", i), 32'(done), 32'd0);
      get = 1'b1;
      step();
    end
  endtask

  task automatic checkEnd(input string tag);
    checkOutput({tag, "_end_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_end_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_end_done"}, 32'(done), 32'd1);
    get = 1'b0;
    step();
    checkOutput({tag, "_done_clear"}, 32'(done), 32'd0);
  endtask

  task automatic loadTest2();
    exp_q = {9'h02A, 9'h100, 9'h102, 9'h100, 9'h103,
             9'h02B, 9'h100, 9'h101, 9'h100, 9'h102, 9'h02C};
    pushPixels(4, C1234_0, C1234_1, C1234_2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    start = 1'b0;
    get = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; colour = '0;
    step();
    step();
    checkOutput("rst_out", 32'(out), 32'h000);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    step();

    $display("[TB] single-pixel fill");
    exp_q = {9'h02A, 9'h100, 9'h100, 9'h100, 9'h100,
             9'h02B, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02C};
    pushPixels(1, F800_0, F800_1, F800_2);
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd0, 16'hF800);
    popWords(0, exp_q.size() - 1);
    checkEnd("t1");

    $display("[TB] 2x2 fill");
    loadTest2();
    applyStimulus(8'd2, 8'd3, 8'd1, 8'd2, 16'h1234);
    popWords(0, exp_q.size() - 1);
    checkEnd("t2");

    $display("[TB] consumer stall");
    loadTest2();
    applyStimulus(8'd2, 8'd3, 8'd1, 8'd2, 16'h1234);
    popWords(0, 2);
    get = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("stall_out%0d", c), 32'(out), 32'h100);
      checkOutput($sformatf("stall_empty%0d", c), 32'(empty), 32'd0);
      step();
    end
    popWords(3, exp_q.size() - 1);
    checkEnd("t3");

    $display("[TB] invalid window and start while busy");
    applyStimulus(8'd5, 8'd4, 8'd0, 8'd0, 16'h0F0F);
    checkOutput("inv_empty", 32'(empty), 32'd1);
    checkOutput("inv_busy", 32'(busy), 32'd0);
    checkOutput("inv_done", 32'(done), 32'd1);
    step();
    checkOutput("inv_done_clear", 32'(done), 32'd0);
    checkOutput("inv_empty2", 32'(empty), 32'd1);
    exp_q = {9'h02A, 9'h100, 9'h100, 9'h100, 9'h100,
             9'h02B, 9'h100, 9'h100, 9'h100, 9'h100, 9'h02C};
    pushPixels(1, F800_0, F800_1, F800_2);
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd0, 16'hF800);
    x1 = 8'd200; y1 = 8'd9; colour = 16'h0000;
    start = 1'b1;
    get = 1'b1;
    checkOutput("busy_start_word0", 32'(out), 32'h02A);
    step();
    start = 1'b0;
    popWords(1, exp_q.size() - 1);
    checkEnd("t4");

    $display("[TB] full square with mid-sequence reset");
    exp_q = {9'h02A, 9'h100, 9'h100, 9'h100, 9'h1FF,
             9'h02B, 9'h100, 9'h100, 9'h100, 9'h1FF, 9'h02C};
    pushPixels(600, CABCD_0, CABCD_1, CABCD_2);
    applyStimulus(8'd0, 8'd255, 8'd0, 8'd255, 16'hABCD);
    popWords(0, 999);
    checkOutput("pre_rst_word1000", 32'(out), 32'(exp_q[1000]));
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_empty", 32'(empty), 32'd1);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_out", 32'(out), 32'h000);
    get = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    checkOutput("post_rst_empty", 32'(empty), 32'd1);
    loadTest2();
    applyStimulus(8'd2, 8'd3, 8'd1, 8'd2, 16'h1234);
    popWords(0, exp_q.size() - 1);
    checkEnd("t5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
